// File: rtl/seg_scan_multi.sv
// seg_scan_multi: multiplexed 7-segment scanner with multi-cycle binary-to-BCD loader.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zeros in decimal mode.
module seg_scan_multi #(
  parameter int DIGITS     = 6,
  parameter int BIN_W      = 20,
  parameter int SCAN_DIV   = 65536,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [4*DIGITS-1:0]   iNum,
  input  logic                  iIsHex,
  input  logic [DIGITS-1:0]     iDot,
  input  logic                  iLoad,
  output logic                  oBusy,
  output logic                  oOvf,
  output logic [7:0]            oSeg,
  output logic [DIGITS-1:0]     oSel
);

  localparam int NW = 4 * DIGITS;
  localparam int SW = NW + BIN_W;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int KW = $clog2(BIN_W + 1);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  localparam logic [7:0] SEG_RST =
    (ACTIVE_LOW != 0) ? 8'hC0 : 8'h3F;
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);
  localparam logic [DIGITS-1:0] SEL_RST =
    (ACTIVE_LOW != 0) ? ~SEL_ONE : SEL_ONE;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              ovf_q;
  logic              acc_q;
  logic [SW-1:0]     sh_q;
  logic [KW-1:0]     cnt_q;
  logic [NW-1:0]     disp_q;
  logic [DIGITS-1:0] dot_q;
  logic [DIGITS-1:0] dot_pend_q;
  logic              dec_q;
  logic              dash_q;

  logic [CW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h3F;
      4'h1: c = 7'h06;
      4'h2: c = 7'h5B;
      4'h3: c = 7'h4F;
      4'h4: c = 7'h66;
      4'h5: c = 7'h6D;
      4'h6: c = 7'h7D;
      4'h7: c = 7'h07;
      4'h8: c = 7'h7F;
      4'h9: c = 7'h6F;
      4'hA: c = 7'h77;
      4'hB: c = 7'h7C;
      4'hC: c = 7'h39;
      4'hD: c = 7'h5E;
      4'hE: c = 7'h79;
      default: c = 7'h71;
    endcase
    return c;
  endfunction

  // One double-dabble step: add-3 correction on the BCD field, then shift.
  logic [NW-1:0] adj;
  logic [SW-1:0] sh_next;
  logic          carry;
  logic [3:0]    bnib;

  always_comb begin
    adj  = '0;
    bnib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bnib = sh_q[BIN_W + 4*i +: 4];
      adj[4*i +: 4] = (bnib >= 4'd5) ? bnib + 4'd3 : bnib;
    end
    carry   = adj[NW-1];
    sh_next = {adj[NW-2:0], sh_q[BIN_W-1:0], 1'b0};
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      dot_q      <= '0;
      dot_pend_q <= '0;
      dec_q      <= 1'b1;
      dash_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iLoad && iIsHex) begin
            disp_q <= iNum;
            dot_q  <= iDot;
            ovf_q  <= 1'b0;
            dec_q  <= 1'b0;
            dash_q <= 1'b0;
          end else if (iLoad) begin
            sh_q       <= {{NW{1'b0}}, iNum[BIN_W-1:0]};
            acc_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            dot_pend_q <= iDot;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q  <= sh_next;
          acc_q <= acc_q | carry;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == KW'(BIN_W - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          ovf_q  <= acc_q;
          dash_q <= acc_q;
          dec_q  <= 1'b1;
          dot_q  <= dot_pend_q;
          if (!acc_q) begin
            disp_q <= sh_q[SW-1 -: NW];
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic [DIGITS-1:0] lz;
  logic              nz;

  always_comb begin
    lz = '0;
    nz = 1'b0;
    if (LZB_EN) begin
      for (int k = DIGITS - 1; k >= 1; k--) begin
        nz    = nz | (disp_q[4*k +: 4] != 4'd0);
        lz[k] = dec_q & ~dash_q & ~nz;
      end
    end
  end

  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic [6:0]        cur_code;
  logic [DIGITS-1:0] sel_raw;

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_raw   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib    = disp_q[4*k +: 4];
        cur_dp     = dot_q[k];
        cur_blank  = lz[k];
        sel_raw[k] = 1'b1;
      end
    end

    if (dash_q) begin
      cur_code = 7'h40;
    end else if (cur_blank) begin
      cur_code = 7'h00;
    end else begin
      cur_code = hex7(cur_nib);
    end

    seg_d = {cur_dp, cur_code};
    sel_d = sel_raw;
    if (ACTIVE_LOW != 0) begin
      seg_d = ~seg_d;
      sel_d = ~sel_raw;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      scan_q <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_RST;
      sel_q  <= SEL_RST;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
    end
  end

  assign oBusy = busy_q;
  assign oOvf  = ovf_q;
  assign oSeg  = seg_q;
  assign oSel  = sel_q;

endmodule

// File: tb/tb_seg_scan_multi.sv
// tb_seg_scan_multi: table vectors, hand sequences and random loads
// checked against a decimal/hex display model.
module tb_seg_scan_multi;

  localparam int D  = 6;
  localparam int BW = 20;
  localparam int SD = 4;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic [23:0]   iNum;
  logic          iIsHex;
  logic [5:0]    iDot;
  logic          iLoad;
  logic          oBusy;
  logic          oOvf;
  logic [7:0]    oSeg;
  logic [5:0]    oSel;

  int checks   = 0;
  int failures = 0;

  seg_scan_multi #(
    .DIGITS(D), .BIN_W(BW), .SCAN_DIV(SD), .ACTIVE_LOW(1)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iNum(iNum), .iIsHex(iIsHex),
    .iDot(iDot), .iLoad(iLoad), .oBusy(oBusy), .oOvf(oOvf),
    .oSeg(oSeg), .oSel(oSel)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Display model: what the panel should show, in decimal/hex terms.
  logic        m_hex;
  int unsigned m_val;
  logic [5:0]  m_dot;
  logic        m_ovf;

  task automatic model_reset();
    m_hex = 1'b0;
    m_val = 0;
    m_dot = '0;
    m_ovf = 1'b0;
  endtask

  function automatic logic [6:0] seg_of(input int unsigned n);
    case (n)
      0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;
      3: return 7'h4F;   4: return 7'h66;   5: return 7'h6D;
      6: return 7'h7D;   7: return 7'h07;   8: return 7'h7F;
      9: return 7'h6F;   10: return 7'h77;  11: return 7'h7C;
      12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] exp_digit(input int k);
    logic [6:0]  code;
    int unsigned p;
    int unsigned q;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (m_ovf) begin
      code = 7'h40;
    end else if (m_hex) begin
      code = seg_of((m_val >> (4 * k)) & 15);
    end else begin
      q    = m_val / p;
      code = seg_of(q % 10);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (k > 0 && q == 0) code = 7'h00;
`endif
    end
    return {m_dot[k], code};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sel_index(input logic [5:0] sel_n);
    logic [5:0] s;
    int idx;
    s   = ~sel_n;
    idx = -1;
    for (int k = 0; k < D; k++) if (s[k]) idx = k;
    if ($countones(s) != 1) idx = -1;
    return idx;
  endfunction

  task automatic capture(output logic [5:0][7:0] fr, output int bad1h,
                         output logic [5:0] seen);
    int idx;
    fr    = '0;
    seen  = '0;
    bad1h = 0;
    for (int c = 0; c < 2 * D * SD; c++) begin
      @(negedge iCLK);
      idx = sel_index(oSel);
      if (idx < 0) bad1h++;
      else begin
        fr[idx]   = ~oSeg;
        seen[idx] = 1'b1;
      end
    end
  endtask

  task automatic check_frame(input string tag);
    logic [5:0][7:0] fr;
    logic [5:0]      seen;
    int              bad1h;
    capture(fr, bad1h, seen);
    check({tag, "_onehot"}, bad1h, 0);
    check({tag, "_seen"}, {26'd0, seen}, 32'h3F);
    for (int k = 0; k < D; k++)
      check($sformatf("%s_d%0d", tag, k), {24'd0, fr[k]},
            {24'd0, exp_digit(k)});
  endtask

  // Load, watch busy/hold for a decimal conversion, then update the model.
  task automatic do_load(input logic hex, input logic [23:0] num,
                         input logic [5:0] dot, input int extra_at,
                         input string tag);
    int          busy_n;
    int          hold_bad;
    int          idx;
    logic [7:0]  cur;
    int unsigned v;
    @(negedge iCLK);
    iIsHex = hex;
    iNum   = num;
    iDot   = dot;
    iLoad  = 1'b1;
    @(negedge iCLK);
    iLoad = 1'b0;
    busy_n   = 0;
    hold_bad = 0;
    if (!hex) begin
      for (int c = 0; c < 100 && oBusy; c++) begin
        idx = sel_index(oSel);
        cur = ~oSeg;
        if (idx < 0 || cur !== exp_digit(idx)) hold_bad++;
        busy_n++;
        if (c == extra_at) begin
          iLoad  = 1'b1;
          iIsHex = 1'b0;
          iNum   = 24'd7;
          iDot   = ~dot;
        end else begin
          iLoad = 1'b0;
        end
        @(negedge iCLK);
      end
      iLoad = 1'b0;
      check({tag, "_busy_len"}, busy_n, BW + 1);
      check({tag, "_hold"}, hold_bad, 0);
      v = num[19:0];
      if (v > 999999) m_ovf = 1'b1;
      else begin
        m_ovf = 1'b0;
        m_val = v;
      end
      m_hex = 1'b0;
      m_dot = dot;
      repeat (2) @(negedge iCLK);
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (oBusy) busy_n++;
        @(negedge iCLK);
      end
      check({tag, "_hex_busy"}, busy_n, 0);
      m_hex = 1'b1;
      m_val = num;
      m_ovf = 1'b0;
      m_dot = dot;
    end
  endtask

  typedef struct packed {
    logic            hex;
    logic [23:0]     num;
    logic [5:0]      dot;
    logic            ovf;
    logic [5:0][7:0] seg;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [5:0][7:0] fr;
    logic [5:0]      seen;
    int              bad1h;
    int              bad;
    logic [5:0]      exp_sel;

    vt[0] = '{1'b1, 24'hABC123, 6'h00, 1'b0,
              {8'h77, 8'h7C, 8'h39, 8'h06, 8'h5B, 8'h4F}};
    vt[1] = '{1'b0, 24'd987654, 6'h00, 1'b0,
              {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66}};
    vt[2] = '{1'b0, 24'd1000000, 6'h00, 1'b1,
              {8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40}};
    vt[3] = '{1'b1, 24'h456789, 6'b100001, 1'b0,
              {8'hE6, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'hEF}};
    vt[4] = '{1'b0, 24'd999999, 6'h00, 1'b0,
              {8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F}};
    vt[5] = '{1'b0, 24'd1048575, 6'b000010, 1'b1,
              {8'h40, 8'h40, 8'h40, 8'h40, 8'hC0, 8'h40}};
    vt[6] = '{1'b1, 24'h000000, 6'h3F, 1'b0,
              {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vt[7] = '{1'b0, 24'd100000, 6'h00, 1'b0,
              {8'h06, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};

    iRST = 1'b1; iLoad = 1'b0; iIsHex = 1'b0;
    iNum = '0;   iDot = '0;
    model_reset();
    repeat (3) @(negedge iCLK);
    check("rst_seg", {24'd0, oSeg}, 32'hC0);
    check("rst_sel", {26'd0, oSel}, 32'h3E);
    check("rst_busy", {31'd0, oBusy}, 0);
    check("rst_ovf", {31'd0, oOvf}, 0);
    iRST = 1'b0;

    // Scan walk: each digit held SD cycles, wrapping after the last one.
    for (int n = 1; n <= 2 * D * SD; n++) begin
      @(negedge iCLK);
      exp_sel = ~(6'b1 << (((n - 1) / SD) % D));
      check($sformatf("walk_sel_%0d", n), {26'd0, oSel}, {26'd0, exp_sel});
    end
    check_frame("rst_frame");

    for (int t = 0; t < 8; t++) begin
      do_load(vt[t].hex, vt[t].num, vt[t].dot, -1, $sformatf("vec%0d", t));
      capture(fr, bad1h, seen);
      check($sformatf("vec%0d_onehot", t), bad1h, 0);
      for (int k = 0; k < D; k++)
        check($sformatf("vec%0d_d%0d", t, k), {24'd0, fr[k]},
              {24'd0, vt[t].seg[k]});
      check($sformatf("vec%0d_ovf", t), {31'd0, oOvf}, {31'd0, vt[t].ovf});
    end

    // Second load mid-conversion is ignored.
    do_load(1'b0, 24'd42, 6'h00, 4, "ign");
    check_frame("ign");
    check("ign_ovf", {31'd0, oOvf}, 0);

    // Reset in the middle of a conversion.
    @(negedge iCLK);
    iIsHex = 1'b0; iNum = 24'd123456; iDot = 6'h00; iLoad = 1'b1;
    @(negedge iCLK);
    iLoad = 1'b0;
    repeat (9) @(negedge iCLK);
    check("abort_busy_pre", {31'd0, oBusy}, 1);
    #2 iRST = 1'b1;
    #1;
    check("abort_busy", {31'd0, oBusy}, 0);
    check("abort_sel", {26'd0, oSel}, 32'h3E);
    check("abort_seg", {24'd0, oSeg}, 32'hC0);
    @(negedge iCLK);
    iRST = 1'b0;
    model_reset();
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge iCLK);
      if (oBusy) bad++;
    end
    check("abort_no_restart", bad, 0);
    check_frame("abort");

    // Load coinciding with reset: reset wins.
    do_load(1'b1, 24'h654321, 6'h15, -1, "pre");
    @(negedge iCLK);
    iRST = 1'b1; iLoad = 1'b1; iIsHex = 1'b1; iNum = 24'h111111;
    @(negedge iCLK);
    iRST = 1'b0; iLoad = 1'b0;
    model_reset();
    check_frame("rstload");

    for (int r = 0; r < 16; r++) begin
      logic        h;
      logic [23:0] n;
      logic [5:0]  d;
      int          ex;
      h = 1'($urandom_range(0, 1));
      n = 24'($urandom);
      d = 6'($urandom);
      if (!h) begin
        case ($urandom_range(0, 2))
          0: n = 24'($urandom_range(0, 999));
          1: n = 24'($urandom_range(1000000, 1048575));
          default: n = 24'($urandom_range(0, 999999));
        endcase
      end
      ex = (r % 4 == 3) ? int'($urandom_range(0, 15)) : -1;
      do_load(h, n, d, ex, $sformatf("rnd%0d", r));
      check_frame($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_ovf", r), {31'd0, oOvf}, {31'd0, m_ovf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
